// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, optional signed mode,
// valid/ready handshake on both operand and result sides.
module div_seq #(
  parameter int WD = 10,
  parameter int WS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          signed_i,
  input  logic [WD-1:0] did,
  input  logic [WS-1:0] div,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] quo,
  output logic [WS-1:0] rem,
  output logic          error
);

  localparam int CW = $clog2(WD + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        r_state;
  logic          r_inReady;
  logic          r_outValid;
  logic          r_error;
  logic          r_signed;
  logic          r_negD;
  logic          r_negS;
  logic [WD-1:0] r_magD;
  logic [WS-1:0] r_magS;
  logic [WS-1:0] r_rem;
  logic [WD-1:0] r_quo;
  logic [CW-1:0] r_cnt;

  logic          w_negD;
  logic          w_negS;
  logic [WD-1:0] w_magD;
  logic [WS-1:0] w_magS;
  logic [WS:0]   w_trial;
  logic          w_fits;
  logic [WS-1:0] w_diff;

  // Operand magnitudes; negating the most-negative value yields its correct unsigned magnitude.
  assign w_negD = signed_i & did[WD-1];
  assign w_negS = signed_i & div[WS-1];
  assign w_magD = w_negD ? -did : did;
  assign w_magS = w_negS ? -div : div;

  // The remainder after a successful subtract is below |div|, so the low WS bits suffice.
  assign w_trial = {r_rem, r_magD[WD-1]};
  assign w_fits  = (w_trial >= {1'b0, r_magS});
  assign w_diff  = w_trial[WS-1:0] - r_magS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_error    <= 1'b0;
      r_signed   <= 1'b0;
      r_negD     <= 1'b0;
      r_negS     <= 1'b0;
      r_magD     <= '0;
      r_magS     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_inReady <= 1'b0;
            r_signed  <= signed_i;
            r_negD    <= did[WD-1];
            r_negS    <= div[WS-1];
            r_magD    <= w_magD;
            r_magS    <= w_magS;
            r_cnt     <= CW'(WD);
            if (div == '0) begin
              r_quo      <= '1;
              r_rem      <= did[WS-1:0];
              r_error    <= 1'b1;
              r_outValid <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_quo   <= '0;
              r_rem   <= '0;
              r_error <= 1'b0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_magD <= r_magD << 1;
          if (w_fits) begin
            r_rem <= w_diff;
            r_quo <= {r_quo[WD-2:0], 1'b1};
          end else begin
            r_rem <= w_trial[WS-1:0];
            r_quo <= {r_quo[WD-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          // Truncation toward zero; the remainder follows the dividend's sign.
          if (r_signed && (r_negD != r_negS)) begin
            r_quo <= -r_quo;
          end
          if (r_signed && r_negD) begin
            r_rem <= -r_rem;
          end
          r_outValid <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_inReady <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign quo       = r_quo;
  assign rem       = r_rem;
  assign error     = r_error;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes reference results computed with
// plain integer arithmetic; an independent monitor checks each delivered result.
module tb_div_seq;

  localparam int WD = 10;
  localparam int WS = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          signed_i;
  logic [WD-1:0] did;
  logic [WS-1:0] div;
  logic          out_valid;
  logic          out_ready;
  logic [WD-1:0] quo;
  logic [WS-1:0] rem;
  logic          error;

  typedef struct {
    logic [WD-1:0] quo;
    logic [WS-1:0] rem;
    logic          err;
    int            lat;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic randReady = 1'b0;
  logic prevValid = 1'b0;

  div_seq #(.WD(WD), .WS(WS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signed_i(signed_i), .did(did), .div(div), .out_valid(out_valid),
    .out_ready(out_ready), .quo(quo), .rem(rem), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: SV integer division already truncates toward zero with the dividend's remainder sign.
  function automatic exp_t model(input logic s, input logic [WD-1:0] a, input logic [WS-1:0] b);
    exp_t e;
    int sa, sb2, q, r;
    if (b == '0) begin
      e.quo = '1;
      e.rem = a[WS-1:0];
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      if (s) begin
        sa  = $signed(a);
        sb2 = $signed(b);
      end else begin
        sa  = int'(a);
        sb2 = int'(b);
      end
      q = sa / sb2;
      r = sa % sb2;
      e.quo = q[WD-1:0];
      e.rem = r[WS-1:0];
      e.err = 1'b0;
      e.lat = WD + 2;
    end
    e.due = 0;
    return e;
  endfunction

  task automatic applyStimulus(input logic s, input logic [WD-1:0] a, input logic [WS-1:0] b);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    e = model(s, a, b);
    e.due = cyc + e.lat;
    sb.push_back(e);
    in_valid = 1'b1;
    signed_i = s;
    did      = a;
    div      = b;
    @(negedge clk);
    in_valid = 1'b0;
    did      = WD'($urandom);
    div      = WS'($urandom);
    signed_i = 1'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: latency on the rising edge of out_valid, values on each accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prevValid <= 1'b0;
    end else begin
      if (out_valid && !prevValid) begin
        if (sb.size() == 0) checkOutput("spurious_valid", 32'd1, 32'd0);
        else checkOutput("latency", 32'(cyc), 32'(sb[0].due));
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("quo", 32'(quo), 32'(e.quo));
        checkOutput("rem", 32'(rem), 32'(e.rem));
        checkOutput("error", 32'(error), 32'(e.err));
      end
      prevValid <= out_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    exp_t hold;
    int   n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    signed_i  = 1'b0;
    did       = '0;
    div       = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_quo", 32'(quo), 32'd0);
    checkOutput("reset_rem", 32'(rem), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 10'd1000, 5'd7);
    applyStimulus(1'b1, 10'h39C, 5'd7);
    applyStimulus(1'b1, 10'd100, 5'h19);
    applyStimulus(1'b0, 10'd55, 5'd0);
    applyStimulus(1'b0, 10'd1023, 5'd1);
    applyStimulus(1'b0, 10'd0, 5'd13);
    applyStimulus(1'b1, 10'h200, 5'h1F);
    applyStimulus(1'b1, 10'h3FF, 5'd0);
    waitDrain();

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    hold = model(1'b0, 10'd1000, 5'd7);
    applyStimulus(1'b0, 10'd1000, 5'd7);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (20) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_quo", 32'(quo), 32'(hold.quo));
      checkOutput("bp_rem", 32'(rem), 32'(hold.rem));
      checkOutput("bp_error", 32'(error), 32'(hold.err));
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Reset in the middle of an iteration sequence.
    applyStimulus(1'b0, 10'd1000, 5'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_quo", 32'(quo), 32'd0);
    checkOutput("midrst_rem", 32'(rem), 32'd0);
    applyStimulus(1'b0, 10'd999, 5'd9);
    waitDrain();

    randReady = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic          s;
      logic [WD-1:0] a;
      logic [WS-1:0] b;
      s = 1'($urandom_range(0, 1));
      a = WD'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : WS'($urandom);
      applyStimulus(s, a, b);
    end
    waitDrain();
    randReady = 1'b0;
    out_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
